// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter that shares one 8N1 UART byte transmitter among N_REQ
// byte sources. A winning requester's byte is captured at grant and presented
// to the transmitter with a level-style tx_en. The transmitter raising busy
// means it has taken the byte. At that point the requester gets a one-cycle
// ack and the round-robin pointer moves past it. If busy never rises within
// ISSUE_TIMEOUT cycles, the grant is dropped with a timeout_err pulse. That
// requester is retried next because the pointer does not advance.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   req_valid    per-requester byte-pending level
//   req_data     flattened bytes, requester i at [8i+7:8i]
//   req_ack      one-cycle pulse, requester i's byte accepted (at most one-hot)
//   tx_busy      transmitter busy
//   tx_done      transmitter done (monitored only)
//   tx_en        transmitter start level
//   tx_data      byte to the transmitter
//   grant_id     index of current / last granted requester
//   active       arbiter holds a grant (ISSUE or WAIT)
//   timeout_err  one-cycle pulse when an issue attempt times out
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int N_REQ         = 4,
  parameter int ISSUE_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ack,
  input  logic                     tx_busy,
  input  logic                     tx_done,
  output logic                     tx_en,
  output logic [7:0]               tx_data,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     active,
  output logic                     timeout_err
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(ISSUE_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [GW-1:0]   rr_reg, rr_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            tx_en_next;
  logic [7:0]      tx_data_next;
  logic [N_REQ-1:0] req_ack_next;
  logic [GW-1:0]   grant_id_next;
  logic            active_next;
  logic            timeout_err_next;

  // tx_done plays no part in sequencing; busy alone gates each byte.
  logic unused_tx_done;
  assign unused_tx_done = tx_done;

  // Unpack the flattened byte bus so the winner can index it directly.
  logic [7:0] req_bytes [N_REQ];
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_bytes[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  // Modulo-N_REQ add; correct for N_REQ that is not a power of two.
  function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base,
                                             input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return GW'(s);
  endfunction

  // Winner: first pending requester at or after the rr pointer, wrapping.
  // Scanning offsets from highest to lowest lets the smallest offset win.
  logic          any_valid;
  logic [GW-1:0] winner;
  always_comb begin
    any_valid = 1'b0;
    winner    = rr_reg;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_add(rr_reg, k)]) begin
        any_valid = 1'b1;
        winner    = wrap_add(rr_reg, k);
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    rr_next          = rr_reg;
    cnt_next         = cnt_reg;
    tx_en_next       = tx_en;
    tx_data_next     = tx_data;
    req_ack_next     = '0;
    grant_id_next    = grant_id;
    active_next      = active;
    timeout_err_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!tx_busy && any_valid) begin
          tx_data_next  = req_bytes[winner];
          grant_id_next = winner;
          tx_en_next    = 1'b1;
          active_next   = 1'b1;
          cnt_next      = '0;
          state_next    = ISSUE;
        end
      end
      ISSUE: begin
        if (tx_busy) begin
          tx_en_next             = 1'b0;
          req_ack_next[grant_id] = 1'b1;
          rr_next                = wrap_add(grant_id, 1);
          state_next             = WAIT;
        end else if (cnt_reg == CW'(ISSUE_TIMEOUT - 1)) begin
          // Pointer stays put so the same requester is retried.
          tx_en_next       = 1'b0;
          timeout_err_next = 1'b1;
          active_next      = 1'b0;
          state_next       = IDLE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      WAIT: begin
        if (!tx_busy) begin
          active_next = 1'b0;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      rr_reg      <= '0;
      cnt_reg     <= '0;
      tx_en       <= 1'b0;
      tx_data     <= '0;
      req_ack     <= '0;
      grant_id    <= '0;
      active      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rr_reg      <= rr_next;
      cnt_reg     <= cnt_next;
      tx_en       <= tx_en_next;
      tx_data     <= tx_data_next;
      req_ack     <= req_ack_next;
      grant_id    <= grant_id_next;
      active      <= active_next;
      timeout_err <= timeout_err_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Bench for uart_tx_arbiter. It contains three pieces of support logic:
//   - requester queues whose heads drive req_valid / req_data;
//   - an 8N1 transmitter model with a one-cycle cleanup after busy falls,
//     plus a "stuck" mode in which busy never rises;
//   - a monitor that logs grants, acks, tx_en run lengths, timeout pulses
//     and the bytes decoded from the serial line.
// Each scenario task drives traffic and checks the logs against values taken
// from the arbiter's rules. Round-robin order comes from rr_pick.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TO  = 16;
  localparam int BIT = 4;   // clocks per serial bit in the transmitter model

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     req_ack;
  logic             tx_busy;
  logic             tx_done;
  logic             tx_en;
  logic [7:0]       tx_data;
  logic [$clog2(N)-1:0] grant_id;
  logic             active;
  logic             timeout_err;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .ISSUE_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ack(req_ack),
    .tx_busy(tx_busy), .tx_done(tx_done),
    .tx_en(tx_en), .tx_data(tx_data),
    .grant_id(grant_id), .active(active), .timeout_err(timeout_err)
  );

  // ---------------- requesters: hold head byte until acked ----------------
  logic [7:0] rq [N][$];
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) rq[i].delete();
      else if (req_ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      req_valid[i]       = (rq[i].size() > 0);
      req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
    end
  end

  // ---------------- transmitter model ----------------
  logic       stuck = 1'b0;
  logic       txd;
  logic       cleanup;
  logic [9:0] frame;
  int         bitn, tick;
  always @(posedge clk) begin
    if (rst) begin
      tx_busy <= 1'b0; tx_done <= 1'b0; txd <= 1'b1; cleanup <= 1'b0;
      bitn <= 0; tick <= 0; frame <= '1;
    end else begin
      tx_done <= 1'b0;
      if (!tx_busy) begin
        if (cleanup) cleanup <= 1'b0;
        else if (tx_en && !stuck) begin
          tx_busy <= 1'b1; frame <= {1'b1, tx_data, 1'b0};
          txd <= 1'b0; bitn <= 0; tick <= 0;
        end
      end else begin
        if (bitn == 9 && tick == BIT - 2) begin
          // busy drops during the last stop-bit clock
          tx_busy <= 1'b0; cleanup <= 1'b1; tx_done <= 1'b1;
        end else if (tick == BIT - 1) begin
          tick <= 0; bitn <= bitn + 1; txd <= frame[bitn + 1];
        end else begin
          tick <= tick + 1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic [N-1:0] vld_edge;
  always @(posedge clk) vld_edge <= req_valid;

  int           cyc = 0;
  logic         en_d, busy_d, rx_on;
  int           en_len, to_cnt, stop_bad, rx_t, rx_k;
  logic [7:0]   rx_byte;
  int           grant_q[$];
  logic [7:0]   gdata_q[$];
  logic [N-1:0] gvld_q[$];
  logic [N-1:0] ack_q[$];
  int           en_len_q[$], en_rise_q[$], busy_fall_q[$], rx_start_q[$];
  logic [7:0]   rx_q[$];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      grant_q.delete(); gdata_q.delete(); gvld_q.delete(); ack_q.delete();
      en_len_q.delete(); en_rise_q.delete(); busy_fall_q.delete();
      rx_start_q.delete(); rx_q.delete();
      en_d = 1'b0; busy_d = 1'b0; rx_on = 1'b0;
      en_len = 0; to_cnt = 0; stop_bad = 0; rx_t = 0; rx_byte = 8'h00;
    end else begin
      if (tx_en && !en_d) begin
        grant_q.push_back(int'(grant_id)); gdata_q.push_back(tx_data);
        gvld_q.push_back(vld_edge); en_rise_q.push_back(cyc);
      end
      if (tx_en) en_len++;
      else if (en_d) begin en_len_q.push_back(en_len); en_len = 0; end
      if (req_ack != '0) ack_q.push_back(req_ack);
      if (timeout_err) to_cnt++;
      if (!tx_busy && busy_d) busy_fall_q.push_back(cyc);
      if (!rx_on) begin
        if (txd == 1'b0) begin rx_on = 1'b1; rx_t = 0; rx_start_q.push_back(cyc); end
      end else begin
        rx_t++;
        if (rx_t % BIT == BIT / 2) begin
          rx_k = rx_t / BIT;
          if (rx_k >= 1 && rx_k <= 8) rx_byte[rx_k - 1] = txd;
          else if (rx_k == 9) begin
            if (txd !== 1'b1) stop_bad++;
            rx_q.push_back(rx_byte); rx_on = 1'b0;
          end
        end
      end
      en_d = tx_en; busy_d = tx_busy;
    end
  end

  // ---------------- reference: round-robin pick ----------------
  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int o = 0; o < N; o++) if (v[(p + o) % N]) return (p + o) % N;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stuck = 1'b0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    compared++; if (tx_en !== 1'b0) begin mismatched++; $display("FAIL rst_tx_en: got %b want 0", tx_en); end
    compared++; if (tx_data !== 8'h00) begin mismatched++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
    compared++; if (req_ack !== 4'b0000) begin mismatched++; $display("FAIL rst_req_ack: got %b want 0000", req_ack); end
    compared++; if (grant_id !== 2'd0) begin mismatched++; $display("FAIL rst_grant_id: got %0d want 0", grant_id); end
    compared++; if (active !== 1'b0) begin mismatched++; $display("FAIL rst_active: got %b want 0", active); end
    compared++; if (timeout_err !== 1'b0) begin mismatched++; $display("FAIL rst_timeout_err: got %b want 0", timeout_err); end
    rst = 1'b0;
  endtask

  task automatic test_single_byte();
    int n;
    do_reset();
    rq[0].push_back(8'hA5);
    @(negedge clk);
    step();
    compared++; if (tx_en !== 1'b1) begin mismatched++; $display("FAIL single_tx_en: got %b want 1", tx_en); end
    compared++; if (tx_data !== 8'hA5) begin mismatched++; $display("FAIL single_tx_data: got %h want a5", tx_data); end
    compared++; if (grant_id !== 2'd0) begin mismatched++; $display("FAIL single_grant: got %0d want 0", grant_id); end
    compared++; if (active !== 1'b1) begin mismatched++; $display("FAIL single_active: got %b want 1", active); end
    n = 0;
    while (req_ack === 4'b0000 && n < 20) begin step(); n++; end
    compared++; if (n != 2) begin mismatched++; $display("FAIL single_ack_latency: got %0d want 2", n); end
    compared++; if (req_ack !== 4'b0001) begin mismatched++; $display("FAIL single_ack: got %b want 0001", req_ack); end
    compared++; if (tx_en !== 1'b0) begin mismatched++; $display("FAIL single_en_drop: got %b want 0", tx_en); end
    step();
    compared++; if (req_ack !== 4'b0000) begin mismatched++; $display("FAIL single_ack_pulse: got %b want 0000", req_ack); end
    n = 0;
    while (tx_busy === 1'b1 && n < 100) begin step(); n++; end
    compared++; if (active !== 1'b1) begin mismatched++; $display("FAIL single_active_hold: got %b want 1", active); end
    step();
    compared++; if (active !== 1'b0) begin mismatched++; $display("FAIL single_active_drop: got %b want 0", active); end
    n = 0;
    while (rx_q.size() == 0 && n < 100) begin step(); n++; end
    compared++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5 || stop_bad != 0) begin
      mismatched++; $display("FAIL single_serial: got %0d bytes first %h stop_bad %0d want 1 byte a5", rx_q.size(), rx_q[0], stop_bad);
    end
  endtask

  task automatic test_round_robin();
    int n;
    do_reset();
    rq[0].push_back(8'h11); rq[1].push_back(8'h22);
    rq[2].push_back(8'h33); rq[3].push_back(8'h44);
    n = 0;
    while (ack_q.size() < 4 && n < 600) begin step(); n++; end
    compared++; if (grant_q.size() != 4) begin mismatched++; $display("FAIL rr_count: got %0d want 4", grant_q.size()); end
    for (int k = 0; k < 4; k++) begin
      compared++; if (grant_q[k] != k || gdata_q[k] !== 8'(8'h11 * (k + 1))) begin
        mismatched++; $display("FAIL rr_order[%0d]: got id %0d data %h want id %0d data %h", k, grant_q[k], gdata_q[k], k, 8'(8'h11 * (k + 1)));
      end
    end
    rq[0].push_back(8'h55); rq[3].push_back(8'h66);
    n = 0;
    while (ack_q.size() < 6 && n < 400) begin step(); n++; end
    compared++; if (grant_q.size() != 6 || grant_q[4] != 0 || grant_q[5] != 3) begin
      mismatched++; $display("FAIL rr_second: got %0d grants, ids %0d,%0d want 0,3", grant_q.size(), grant_q[4], grant_q[5]);
    end
  endtask

  task automatic test_fairness();
    int n;
    do_reset();
    repeat (4) rq[1].push_back(8'($urandom));
    n = 0;
    while (grant_q.size() < 1 && n < 50) begin step(); n++; end
    rq[2].push_back(8'h99);
    n = 0;
    while (grant_q.size() < 3 && n < 400) begin step(); n++; end
    compared++; if (grant_q.size() < 3 || grant_q[0] != 1 || grant_q[1] != 2 || grant_q[2] != 1) begin
      mismatched++; $display("FAIL fair_order: got %0d,%0d,%0d want 1,2,1", grant_q[0], grant_q[1], grant_q[2]);
    end
    compared++; if (gdata_q[1] !== 8'h99) begin mismatched++; $display("FAIL fair_data: got %h want 99", gdata_q[1]); end
  endtask

  task automatic test_timeout();
    int n;
    logic [7:0] b;
    do_reset();
    stuck = 1'b1;
    b = 8'($urandom);
    rq[2].push_back(b);
    n = 0;
    while (grant_q.size() < 2 && n < 200) begin step(); n++; end
    compared++; if (en_len_q.size() < 1 || en_len_q[0] != TO) begin
      mismatched++; $display("FAIL to_en_len: got %0d want %0d", en_len_q.size() > 0 ? en_len_q[0] : -1, TO);
    end
    compared++; if (to_cnt != 1) begin mismatched++; $display("FAIL to_pulse: got %0d want 1", to_cnt); end
    compared++; if (ack_q.size() != 0) begin mismatched++; $display("FAIL to_no_ack: got %0d acks want 0", ack_q.size()); end
    compared++; if (grant_q.size() < 2 || grant_q[0] != 2 || grant_q[1] != 2 || gdata_q[1] !== b) begin
      mismatched++; $display("FAIL to_regrant: got ids %0d,%0d data %h want 2,2 data %h", grant_q[0], grant_q[1], gdata_q[1], b);
    end
    stuck = 1'b0;
    n = 0;
    while (ack_q.size() < 1 && n < 50) begin step(); n++; end
    compared++; if (ack_q.size() != 1 || ack_q[0] !== 4'b0100) begin
      mismatched++; $display("FAIL to_recover_ack: got %0d acks first %b want 0100", ack_q.size(), ack_q[0]);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    rq[1].push_back(8'h3C);
    n = 0;
    while (ack_q.size() < 1 && n < 50) begin step(); n++; end
    step(); step();
    rst = 1'b1;
    step();
    compared++; if (tx_en !== 1'b0 || active !== 1'b0 || req_ack !== 4'b0000 || grant_id !== 2'd0) begin
      mismatched++; $display("FAIL midrst_outputs: got en %b act %b ack %b gid %0d want 0 0 0000 0", tx_en, active, req_ack, grant_id);
    end
    rst = 1'b0;
    rq[2].push_back(8'hC2); rq[0].push_back(8'h0F);
    n = 0;
    while (grant_q.size() < 1 && n < 50) begin step(); n++; end
    compared++; if (grant_q.size() < 1 || grant_q[0] != 0 || gdata_q[0] !== 8'h0F) begin
      mismatched++; $display("FAIL midrst_first_grant: got id %0d data %h want 0 0f", grant_q[0], gdata_q[0]);
    end
  endtask

  task automatic test_back_to_back();
    int n, gap;
    do_reset();
    rq[0].push_back(8'h5A); rq[0].push_back(8'hC3);
    n = 0;
    while (rx_q.size() < 2 && n < 400) begin step(); n++; end
    compared++; if (rx_q.size() != 2 || rx_q[0] !== 8'h5A || rx_q[1] !== 8'hC3 || stop_bad != 0) begin
      mismatched++; $display("FAIL b2b_bytes: got %0d bytes %h %h want 5a c3", rx_q.size(), rx_q[0], rx_q[1]);
    end
    compared++; if (busy_fall_q.size() < 1 || en_rise_q.size() < 2 || en_rise_q[1] - busy_fall_q[0] != 2) begin
      mismatched++; $display("FAIL b2b_en_delay: got %0d cycles want 2", en_rise_q[1] - busy_fall_q[0]);
    end
    gap = rx_start_q[1] - rx_start_q[0] - 10 * BIT;
    compared++; if (rx_start_q.size() < 2 || gap < 0 || gap > 2) begin
      mismatched++; $display("FAIL b2b_line_gap: got %0d idle cycles want 0..2", gap);
    end
  endtask

  logic [7:0] sb [N][$];
  task automatic test_random();
    int n, ptr, exp;
    logic [7:0] eb, b;
    logic [N-1:0] oh;
    do_reset();
    for (int i = 0; i < N; i++) sb[i].delete();
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 39) == 0) begin
        n = $urandom_range(0, N - 1);
        b = 8'($urandom);
        rq[n].push_back(b); sb[n].push_back(b);
      end
      step();
    end
    n = 0;
    while ((req_valid !== 4'b0000 || active !== 1'b0) && n < 20000) begin step(); n++; end
    compared++; if (req_valid !== 4'b0000 || active !== 1'b0) begin
      mismatched++; $display("FAIL rnd_drain: got valid %b active %b want 0000 0", req_valid, active);
    end
    compared++; if (grant_q.size() != ack_q.size() || grant_q.size() != rx_q.size()) begin
      mismatched++; $display("FAIL rnd_counts: got grants %0d acks %0d bytes %0d want equal", grant_q.size(), ack_q.size(), rx_q.size());
    end
    ptr = 0;
    for (int k = 0; k < grant_q.size(); k++) begin
      exp = rr_pick(gvld_q[k], ptr);
      if (exp < 0) exp = 0;
      eb = (sb[exp].size() > 0) ? sb[exp].pop_front() : 8'h00;
      oh = 4'b0001 << exp;
      compared++; if (grant_q[k] != exp) begin mismatched++; $display("FAIL rnd_grant[%0d]: got %0d want %0d", k, grant_q[k], exp); end
      compared++; if (gdata_q[k] !== eb) begin mismatched++; $display("FAIL rnd_data[%0d]: got %h want %h", k, gdata_q[k], eb); end
      compared++; if (ack_q[k] !== oh) begin mismatched++; $display("FAIL rnd_ack[%0d]: got %b want %b", k, ack_q[k], oh); end
      compared++; if (rx_q[k] !== eb) begin mismatched++; $display("FAIL rnd_serial[%0d]: got %h want %h", k, rx_q[k], eb); end
      ptr = (exp + 1) % N;
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single_byte();
    test_round_robin();
    test_fairness();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
